// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-addressed data memory: sub-word loads with extension,
// read-modify-write for SB/SH. Define LSU_MISALIGN_TRAP_EN to fault on misaligned H/W accesses.
module load_store_unit #(
  parameter int ADDR_W    = 6,
  parameter int MEM_DEPTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_address,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merged_q, merged_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              resp_fault_q, resp_fault_d;

  logic              legal, out_of_range, misaligned, is_sw;
  logic [1:0]        lane;

  // Halfword/word accesses ignore the low address bits they cannot use.
  function automatic logic [1:0] eff_lane(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return {lo[1], 1'b0};
      2'b10:   return 2'b00;
      default: return lo;
    endcase
  endfunction

  function automatic logic req_legal(input logic wr, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b100, 3'b101:         return !wr;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] ln);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    b = 8'(word >> {ln, 3'b000});
    h = 16'(word >> {ln, 3'b000});
    case (f3)
      3'b000:  ext = b;
      3'b001:  ext = h;
      3'b100:  ext = {24'd0, b};
      3'b101:  ext = {16'd0, h};
      default: ext = word;
    endcase
    return ext;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] ln);
    logic [31:0] mask;
    mask = f3[0] ? (32'h0000_FFFF << {ln, 3'b000}) : (32'h0000_00FF << {ln, 3'b000});
    return (word & ~mask) | ((wd << {ln, 3'b000}) & mask);
  endfunction

  assign legal        = req_legal(req_write, req_funct3);
  assign out_of_range = 32'(req_addr[ADDR_W-1:2]) >= 32'(MEM_DEPTH);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned   = 1'b0;
`endif
  assign lane  = eff_lane(funct3_q, addr_q[1:0]);
  assign is_sw = write_q && (funct3_q == 3'b010);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      merged_q     <= 32'd0;
      resp_data_q  <= 32'd0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merged_q     <= merged_d;
      resp_data_q  <= resp_data_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    merged_d     = merged_q;
    resp_data_d  = resp_data_q;
    resp_fault_d = resp_fault_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (!legal || out_of_range || misaligned) begin
            resp_data_d  = 32'd0;
            resp_fault_d = 1'b1;
            state_d      = RESP;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!write_q) begin
          resp_data_d = load_extract(mem_read_data, funct3_q, lane);
          state_d     = RESP;
        end else if (is_sw) begin
          resp_data_d = 32'd0;
          state_d     = RESP;
        end else begin
          merged_d = store_merge(mem_read_data, wdata_q, funct3_q, lane);
          state_d  = WRITE;
        end
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (resp_ready) begin
          resp_data_d  = 32'd0;
          resp_fault_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == IDLE);
    resp_valid     = (state_q == RESP);
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = 4'd0;
    mem_write_data = 32'd0;
    case (state_q)
      ACCESS: begin
        mem_address = addr_q[ADDR_W-1:2];
        if (is_sw) begin
          mem_write      = 1'b1;
          mem_write_data = wdata_q;
        end else begin
          mem_read = 1'b1;
        end
      end
      WRITE: begin
        mem_address    = addr_q[ADDR_W-1:2];
        mem_write      = 1'b1;
        mem_write_data = merged_q;
      end
      default: ;
    endcase
  end

  assign resp_data  = resp_data_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed test-plan steps then random traffic against a
// byte-addressed reference memory; a word memory stands in for data_memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_data;
  logic        mem_read, mem_write;
  logic [3:0]  mem_address;
  logic [31:0] mem_write_data, mem_read_data;

  logic [31:0] env_mem [0:15];
  logic [7:0]  ref_bytes [0:63];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] got;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_fault(resp_fault), .mem_read(mem_read),
    .mem_write(mem_write), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // data_memory stand-in: combinational read, write on clock, cleared by reset
  assign mem_read_data = env_mem[mem_address];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= 32'd0;
    end else if (mem_write) begin
      env_mem[mem_address] <= mem_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int i);
    return {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
  endfunction

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [5:0] a,
                        input logic [31:0] wd, input int hold, output logic [31:0] got_o);
    int size, ea, v, n, nrd, nwr, bad, hbad, exp_lat, idx;
    logic legal, mis, fault;
    logic [31:0] exp_data;
    logic [3:0]  wr_addr;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    idx   = int'(a) / 4;
    mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis   = (int'(a) % size) != 0;
`endif
    fault = !legal || idx >= 10 || mis;
    ea    = int'(a) - (int'(a) % size);
    v     = 0;
    if (!fault && !w) begin
      if (size == 1) begin
        v = int'(ref_bytes[ea]);
        if (f3 == 3'd0 && v >= 128) v -= 256;
      end else if (size == 2) begin
        v = int'(ref_bytes[ea]) + 256 * int'(ref_bytes[ea+1]);
        if (f3 == 3'd1 && v >= 32768) v -= 65536;
      end else begin
        v = int'(ref_word(idx));
      end
    end
    exp_data = 32'(v);
    exp_lat  = fault ? 1 : (w && size < 4) ? 3 : 2;

    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0; req_wdata = $urandom; req_addr = 6'($urandom); req_funct3 = 3'($urandom);
    n = 0; nrd = 0; nwr = 0; bad = 0; wr_addr = 4'd0;
    while (1) begin
      @(negedge clk);
      n++;
      if (mem_read) nrd++;
      if (mem_write) begin nwr++; wr_addr = mem_address; end
      if (mem_read && mem_write) bad++;
      if (!mem_write && mem_write_data != 32'd0) bad++;
      if (!mem_read && !mem_write && mem_address != 4'd0) bad++;
      if (resp_valid || n >= 12) break;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("resp_fault", {31'd0, resp_fault}, {31'd0, fault});
    chk("resp_data", resp_data, exp_data);
    chk("mem_reads", 32'(nrd), (fault || (w && size == 4)) ? 32'd0 : 32'd1);
    chk("mem_writes", 32'(nwr), (!fault && w) ? 32'd1 : 32'd0);
    chk("mem_bus_rules", 32'(bad), 32'd0);
    if (nwr > 0) chk("write_addr", {28'd0, wr_addr}, 32'(idx));
    got_o = resp_data;
    hbad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_data !== got_o || req_ready !== 1'b0 ||
          resp_fault !== fault) hbad++;
    end
    if (hold > 0) chk("hold_stable", 32'(hbad), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("resp_released", {30'd0, resp_valid, req_ready}, 32'd1);
    if (!fault && w) begin
      for (int k = 0; k < size; k++) ref_bytes[ea+k] = wd[8*k +: 8];
      chk("mem_contents", env_mem[idx], ref_word(idx));
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 6'd0;
    req_wdata = 32'd0; resp_ready = 1'b0;
    for (int i = 0; i < 64; i++) ref_bytes[i] = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ctrl", {26'd0, req_ready, resp_valid, resp_fault, mem_read, mem_write, 1'b0}, 32'h20);
    chk("reset_resp_data", resp_data, 32'd0);
    chk("reset_mem_addr", {28'd0, mem_address}, 32'd0);
    chk("reset_mem_wdata", mem_write_data, 32'd0);

    do_req(1'b1, 3'b010, 6'h08, 32'hDEADBEEF, 0, got);
    do_req(1'b0, 3'b010, 6'h08, 32'd0, 0, got);
    chk("lw_08", got, 32'hDEADBEEF);
    do_req(1'b0, 3'b000, 6'h0B, 32'd0, 0, got);
    chk("lb_0b", got, 32'hFFFFFFDE);
    do_req(1'b0, 3'b100, 6'h0B, 32'd0, 0, got);
    chk("lbu_0b", got, 32'h000000DE);
    do_req(1'b0, 3'b001, 6'h08, 32'd0, 0, got);
    chk("lh_08", got, 32'hFFFFBEEF);
    do_req(1'b0, 3'b101, 6'h0A, 32'd0, 0, got);
    chk("lhu_0a", got, 32'h0000DEAD);
    do_req(1'b1, 3'b000, 6'h09, 32'h00000012, 0, got);
    do_req(1'b0, 3'b010, 6'h08, 32'd0, 0, got);
    chk("lw_after_sb", got, 32'hDEAD12EF);
    do_req(1'b0, 3'b010, 6'h28, 32'd0, 0, got);
    chk("oob_data", got, 32'd0);
    do_req(1'b0, 3'b011, 6'h08, 32'd0, 0, got);
    chk("illegal_data", got, 32'd0);
    do_req(1'b0, 3'b010, 6'h09, 32'd0, 0, got);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_09", got, 32'd0);
`else
    chk("lw_09", got, 32'hDEAD12EF);
`endif
    do_req(1'b0, 3'b001, 6'h0A, 32'd0, 5, got);
    chk("lh_0a_held", got, 32'hFFFFDEAD);

    // reset while an SB sits in its write cycle
    do_req(1'b1, 3'b010, 6'h10, 32'h11223344, 0, got);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 6'h11; req_wdata = 32'hAB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 chk("rmw_write_cycle", {27'd0, mem_write, mem_address}, 32'h14);
    rst = 1'b1;
    #1 chk("midop_ctrl", {26'd0, req_ready, resp_valid, resp_fault, mem_read, mem_write, 1'b0}, 32'h20);
    chk("midop_mem_addr", {28'd0, mem_address}, 32'd0);
    chk("midop_mem_wdata", mem_write_data, 32'd0);
    chk("midop_resp_data", resp_data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 64; i++) ref_bytes[i] = 8'd0;
    chk("dropped_write", env_mem[4], 32'd0);
    do_req(1'b0, 3'b010, 6'h10, 32'd0, 0, got);

    for (int t = 0; t < 80; t++) begin
      do_req(1'($urandom), 3'($urandom), 6'($urandom_range(0, 47)), $urandom,
             int'($urandom_range(0, 2)), got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
